// File: rtl/registerfile_multiport_pkg.sv
// Shared types and constants for the multiport register file and its storage cells.
package registerfile_multiport_pkg;

    typedef enum logic {
        WIPE_IDLE,
        WIPE_SWEEP
    } wipe_state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 4;

    // Port A reads this index as zero while base-address mode is active.
    localparam int R0_IDX = 0;

endpackage

// File: rtl/registerfile_multiport_register_n.sv
// Single storage cell: loads D when write is high, asynchronous active-low clear.
module register_n #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              write,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q <= '0;
        end else if (write) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/registerfile_multiport.sv
// Register file with one write port, two registered read ports with bypass,
// base-address R0 masking on port A, a debug tap and a sequential wipe engine.
module registerfile_multiport
    import registerfile_multiport_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TAP_REG = 12
) (
    input  logic              in_clk,
    input  logic              in_clr,
    input  logic [DATA_W-1:0] in_Cdata,
    input  logic [ADDR_W-1:0] in_Cselect,
    input  logic              in_write,
    input  logic [ADDR_W-1:0] in_Aselect,
    input  logic [ADDR_W-1:0] in_Bselect,
    input  logic              in_read,
    input  logic              in_BAout,
    input  logic              in_wipe,
    output logic [DATA_W-1:0] out_Adata,
    output logic [DATA_W-1:0] out_Bdata,
    output logic              out_valid,
    output logic              out_busy,
    output logic [DATA_W-1:0] out_tap
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    wipe_state_t                  state;
    logic [ADDR_W-1:0]            sweep_cnt;
    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic                         idle;
    logic                         sweeping;
    logic                         write_ok;
    logic                         read_ok;
    logic [DATA_W-1:0]            cell_d;
    logic [DATA_W-1:0]            a_next;
    logic [DATA_W-1:0]            b_next;

    // A wipe request in IDLE pre-empts any write or read sampled at the same edge.
    assign idle     = (state == WIPE_IDLE);
    assign sweeping = (state == WIPE_SWEEP);
    assign write_ok = idle && in_write && !in_wipe;
    assign read_ok  = idle && in_read && !in_wipe;
    assign cell_d   = sweeping ? '0 : in_Cdata;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cell
            logic cell_we;
            assign cell_we = (write_ok && (in_Cselect == ADDR_W'(i)))
                          || (sweeping && (sweep_cnt == ADDR_W'(i)));
            register_n #(.DATA_W(DATA_W)) u_reg (
                .clk   (in_clk),
                .clr   (in_clr),
                .write (cell_we),
                .D     (cell_d),
                .Q     (regs[i])
            );
        end
    endgenerate

    // R0 masking outranks bypass on port A; port B only ever bypasses.
    always_comb begin
        a_next = regs[in_Aselect];
        b_next = regs[in_Bselect];
        if (in_BAout && (in_Aselect == ADDR_W'(R0_IDX))) begin
            a_next = '0;
        end else if (write_ok && (in_Cselect == in_Aselect)) begin
            a_next = in_Cdata;
        end
        if (write_ok && (in_Cselect == in_Bselect)) begin
            b_next = in_Cdata;
        end
    end

    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            state     <= WIPE_IDLE;
            sweep_cnt <= '0;
            out_busy  <= 1'b0;
            out_valid <= 1'b0;
            out_Adata <= '0;
            out_Bdata <= '0;
        end else begin
            case (state)
                WIPE_IDLE: begin
                    out_valid <= read_ok;
                    if (read_ok) begin
                        out_Adata <= a_next;
                        out_Bdata <= b_next;
                    end
                    if (in_wipe) begin
                        state     <= WIPE_SWEEP;
                        sweep_cnt <= '0;
                        out_busy  <= 1'b1;
                    end
                end
                WIPE_SWEEP: begin
                    out_valid <= 1'b0;
                    if (sweep_cnt == LAST_IDX) begin
                        state     <= WIPE_IDLE;
                        sweep_cnt <= '0;
                        out_busy  <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= WIPE_IDLE;
                    sweep_cnt <= '0;
                    out_busy  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_tap = regs[TAP_REG];

endmodule

// File: doc/registerfile_multiport.md
Name: registerfile_multiport

Overview:
Parametrised successor to the 16x32 single-read register file, used in the datapath register stage.
- One write port (C) and two independent read ports (A, B).
- Registered reads with a valid strobe and write-to-read bypass.
- R0 is masked to zero on port A while base-address mode (BAout) is active.
- A multi-cycle wipe sequencer clears the whole file without a reset.
- A fixed debug tap exposes one register, for example R12 for I/O.

Parameters:
DATA_W, 32, register width in bits.
ADDR_W, 4, select width; depth is the localparam DEPTH = 2**ADDR_W.
TAP_REG, 12, index of the register driven on out_tap; must be less than DEPTH.

Ports:
in_clk  input  1  clock; all state updates on posedge.
in_clr  input  1  reset, asynchronous, active-low; all registers, FSM and outputs go to 0/IDLE.
in_Cdata  input  DATA_W  write data.
in_Cselect  input  ADDR_W  write register index.
in_write  input  1  write enable.
in_Aselect  input  ADDR_W  read port A index.
in_Bselect  input  ADDR_W  read port B index.
in_read  input  1  read request for both ports.
in_BAout  input  1  base-address mode; port A reads R0 as zero.
in_wipe  input  1  start a sequential clear of all registers.
out_Adata  output  DATA_W  registered port A data.
out_Bdata  output  DATA_W  registered port B data.
out_valid  output  1  out_Adata/out_Bdata updated by the previous cycle's read.
out_busy  output  1  wipe in progress.
out_tap  output  DATA_W  combinational view of reg[TAP_REG].

Behaviour:
- Reset values: out_Adata 0, out_Bdata 0, out_valid 0, out_busy 0, every register 0, FSM IDLE, sweep counter 0.
- Write:
  - Commits at posedge when in_write=1 and FSM=IDLE.
  - Every index is writable, including R0.
  - Ignored while busy; no queuing.
- Read, latency 1:
  - At a posedge where in_read=1 and FSM=IDLE, out_Adata/out_Bdata capture the selected values and out_valid=1 for that following cycle.
  - Otherwise out_valid=0 and the data outputs hold their last value.
- Bypass:
  - If in_write and in_read are both accepted at the same edge and in_Cselect equals in_Aselect, out_Adata captures in_Cdata (new data), not the old content.
  - Same rule applies independently for port B.
- BAout:
  - When in_BAout=1 and in_Aselect=0 at the capture edge, out_Adata captures 0. This takes priority over bypass.
  - Port B is never masked.
- Tap: out_tap = reg[TAP_REG], combinational. It reflects a write in the cycle after the commit edge.
- Wipe FSM, states IDLE and SWEEP:
  - IDLE with in_wipe=1 at posedge → SWEEP, counter=0.
  - In SWEEP, each posedge clears reg[counter] and increments counter. The edge that clears index DEPTH-1 returns the FSM to IDLE and counter to 0.
  - out_busy is a registered output: 1 exactly while in SWEEP, i.e. DEPTH consecutive cycles starting the cycle after in_wipe is sampled.
  - While busy, in_read, in_write and in_wipe are ignored and out_valid=0.
  - If in_wipe, in_write and in_read coincide in IDLE, the wipe wins: no write, no read, out_valid stays 0.
- Counter width is ADDR_W; no carry bit is needed because the exit condition is counter==DEPTH-1.
- Reset mid-sweep: immediate return to IDLE with everything zero. No partial state survives.
- Out-of-range indices cannot occur, since DEPTH = 2**ADDR_W.

Decomposition:
- Shared package:
  - FSM state enum (WIPE_IDLE, WIPE_SWEEP).
  - Default width constants DATA_W=32, ADDR_W=4.
  - R0 index constant for BAout masking.
- One sub-module: the existing register_32 cell, generalised as register_n (D, clr, clk, write, Q; DATA_W parameter), instantiated DEPTH times from a generate loop.
  - The wipe clear is folded into each cell's write enable with D forced to 0 by the parent.
  - in_clr drives each cell's async clear.
- The write decoder and read muxes stay inline.

Test Plan:
1. Reset then write: release in_clr; write R3=0xDEADBEEF; next cycle read A=3, B=3 → after 1 cycle out_valid=1 and out_Adata=out_Bdata=0xDEADBEEF.
2. Bypass: R5 holds 0x1; same edge write R5=0x12345678 with read A=5, B=0 → out_Adata=0x12345678 and out_Bdata=R0 content.
3. BAout: R0=0xFFFFFFFF; read A=0, B=0 with in_BAout=1 → out_Adata=0, out_Bdata=0xFFFFFFFF; repeat with in_BAout=0 → out_Adata=0xFFFFFFFF.
4. Wipe: fill all 16 registers with index*0x11111111; pulse in_wipe → out_busy high exactly 16 cycles. Writes and reads during that window are ignored with out_valid=0. Afterwards all reads return 0 and out_tap=0.
5. Reset mid-wipe: assert in_clr after 5 sweep cycles → out_busy=0 immediately and all registers 0. A new wipe after release also lasts 16 cycles.
6. Tap: write R12=0xCAFEF00D → out_tap=0xCAFEF00D the cycle after the commit edge; a write to R11 leaves out_tap unchanged.
